// File: rtl/pipe_exe_mem_stage.sv
// Execute stage of the pipeline: the ID/EXE register, the execute ALU and the
// EXE/MEM register. It also exports the EXE and MEM forwarding sources used by
// decode. When decode stalls, a bubble is loaded in place of the instruction.
module pipe_exe_mem_stage (
    input  logic        clk,
    input  logic        clrn,
    input  logic        nostall,
    input  logic [31:0] dpc4,
    input  logic        wreg,
    input  logic        m2reg,
    input  logic        wmem,
    input  logic        aluimm,
    input  logic        shift,
    input  logic        jal,
    input  logic [3:0]  aluc,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] imm,
    input  logic [4:0]  rn,
    output logic        ewreg,
    output logic        em2reg,
    output logic        ewmem,
    output logic [4:0]  ern,
    output logic [31:0] ealu,
    output logic        mwreg,
    output logic        mm2reg,
    output logic        mwmem,
    output logic [4:0]  mrn,
    output logic [31:0] malu,
    output logic [31:0] mb
);

    // ID/EXE register contents that stay internal to this stage
    logic [3:0]  ealuc;
    logic        ealuimm;
    logic        eshift;
    logic        ejal;
    logic [31:0] epc4;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [31:0] eimm;
    logic [4:0]  ern0;

    // ALU operands and result
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_r;

    // ID/EXE register: loads every edge. A stall turns the side-effecting
    // controls (wreg/m2reg/wmem/jal) off so that a bubble travels down the pipe.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            ewreg   <= 1'b0;
            em2reg  <= 1'b0;
            ewmem   <= 1'b0;
            ejal    <= 1'b0;
            ealuc   <= 4'd0;
            ealuimm <= 1'b0;
            eshift  <= 1'b0;
            epc4    <= 32'd0;
            ea      <= 32'd0;
            eb      <= 32'd0;
            eimm    <= 32'd0;
            ern0    <= 5'd0;
        end else begin
            ewreg   <= wreg  & nostall;
            em2reg  <= m2reg & nostall;
            ewmem   <= wmem  & nostall;
            ejal    <= jal   & nostall;
            ealuc   <= aluc;
            ealuimm <= aluimm;
            eshift  <= shift;
            epc4    <= dpc4;
            ea      <= a;
            eb      <= b;
            eimm    <= imm;
            ern0    <= rn;
        end
    end

    // Operand selection: shift amount comes from the immediate's shamt field
    always_comb begin
        alu_a = eshift  ? {27'b0, eimm[10:6]} : ea;
        alu_b = ealuimm ? eimm : eb;
    end

    // ALU: aluc[1:0] picks the operation group, aluc[2] and aluc[3] refine it
    always_comb begin
        alu_r = 32'd0;
        unique case (ealuc[1:0])
            2'b00: alu_r = ealuc[2] ? (alu_a - alu_b) : (alu_a + alu_b);
            2'b01: alu_r = ealuc[2] ? (alu_a | alu_b) : (alu_a & alu_b);
            2'b10: alu_r = ealuc[2] ? {alu_b[15:0], 16'b0} : (alu_a ^ alu_b);
            2'b11: begin
                if (!ealuc[2])
                    alu_r = alu_b << alu_a[4:0];
                else if (ealuc[3])
                    alu_r = $unsigned($signed(alu_b) >>> alu_a[4:0]);
                else
                    alu_r = alu_b >> alu_a[4:0];
            end
            default: alu_r = 32'd0;
        endcase
    end

    // EXE result and destination: jal writes its return address to r31.
    // Both depend only on ID/EXE state, so decode can forward from them freely.
    always_comb begin
        ealu = ejal ? (epc4 + 32'd4) : alu_r;
        ern  = ejal ? 5'd31 : ern0;
    end

    // EXE/MEM register: loads every edge, bubbles arrive with zero controls
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            mwreg  <= 1'b0;
            mm2reg <= 1'b0;
            mwmem  <= 1'b0;
            mrn    <= 5'd0;
            malu   <= 32'd0;
            mb     <= 32'd0;
        end else begin
            mwreg  <= ewreg;
            mm2reg <= em2reg;
            mwmem  <= ewmem;
            mrn    <= ern;
            malu   <= ealu;
            mb     <= eb;
        end
    end

endmodule

// File: tb/tb_pipe_exe_mem_stage.sv
// Directed bench for pipe_exe_mem_stage: reset, ALU sweep, jal, stall bubble,
// store path and asynchronous mid-pipeline reset, with hand-computed results.
module tb_pipe_exe_mem_stage;

    // clock / reset / stimulus signals
    logic        clk;
    logic        clrn;
    logic        nostall;
    logic [31:0] dpc4;
    logic        wreg, m2reg, wmem, aluimm, shift, jal;
    logic [3:0]  aluc;
    logic [31:0] a, b, imm;
    logic [4:0]  rn;
    logic        ewreg, em2reg, ewmem;
    logic [4:0]  ern;
    logic [31:0] ealu;
    logic        mwreg, mm2reg, mwmem;
    logic [4:0]  mrn;
    logic [31:0] malu, mb;

    int n_checks;
    int n_pass;

    pipe_exe_mem_stage dut (
        .clk(clk), .clrn(clrn), .nostall(nostall), .dpc4(dpc4),
        .wreg(wreg), .m2reg(m2reg), .wmem(wmem), .aluimm(aluimm),
        .shift(shift), .jal(jal), .aluc(aluc), .a(a), .b(b), .imm(imm),
        .rn(rn), .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem), .ern(ern),
        .ealu(ealu), .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem),
        .mrn(mrn), .malu(malu), .mb(mb)
    );

    // clock block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // single comparison point for every check
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // advance one rising edge, then sample 1 ns later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // driver: idle instruction (no writes, add 0+0)
    task automatic drive_nop();
        nostall = 1'b1; dpc4 = 32'd0;
        wreg = 1'b0; m2reg = 1'b0; wmem = 1'b0; aluimm = 1'b0; shift = 1'b0; jal = 1'b0;
        aluc = 4'd0; a = 32'd0; b = 32'd0; imm = 32'd0; rn = 5'd0;
    endtask

    // driver: register-register / immediate ALU instruction
    task automatic drive_alu(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb,
                             input logic [31:0] vimm, input logic use_imm, input logic use_shift,
                             input logic [4:0] dst);
        drive_nop();
        wreg = 1'b1; aluc = op; a = va; b = vb; imm = vimm;
        aluimm = use_imm; shift = use_shift; rn = dst;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;

        // reset held with busy inputs
        clrn = 1'b0;
        drive_nop();
        wreg = 1'b1; m2reg = 1'b1; wmem = 1'b1; jal = 1'b1; a = 32'd5; b = 32'd7;
        rn = 5'd3; dpc4 = 32'h40; aluc = 4'b0101; imm = 32'hFFFF;
        step(); step();
        check("rst_ewreg", {31'd0, ewreg}, 32'd0);
        check("rst_em2reg", {31'd0, em2reg}, 32'd0);
        check("rst_ewmem", {31'd0, ewmem}, 32'd0);
        check("rst_ern", {27'd0, ern}, 32'd0);
        check("rst_ealu", ealu, 32'd0);
        check("rst_mwreg", {31'd0, mwreg}, 32'd0);
        check("rst_mm2reg", {31'd0, mm2reg}, 32'd0);
        check("rst_mwmem", {31'd0, mwmem}, 32'd0);
        check("rst_mrn", {27'd0, mrn}, 32'd0);
        check("rst_malu", malu, 32'd0);
        check("rst_mb", mb, 32'd0);

        // release, then add 5+7 -> r3
        clrn = 1'b1;
        drive_alu(4'b0000, 32'd5, 32'd7, 32'd0, 1'b0, 1'b0, 5'd3);
        step();
        check("add_ealu", ealu, 32'd12);
        check("add_ern", {27'd0, ern}, 32'd3);
        check("add_ewreg", {31'd0, ewreg}, 32'd1);

        // sub 3-5 follows; add reaches MEM
        drive_alu(4'b0100, 32'd3, 32'd5, 32'd0, 1'b0, 1'b0, 5'd4);
        step();
        check("add_malu", malu, 32'd12);
        check("add_mrn", {27'd0, mrn}, 32'd3);
        check("add_mwreg", {31'd0, mwreg}, 32'd1);
        check("sub_ealu", ealu, 32'hFFFF_FFFE);

        drive_alu(4'b0110, 32'd0, 32'd0, 32'h1234, 1'b1, 1'b0, 5'd5);
        step();
        check("lui_ealu", ealu, 32'h1234_0000);

        drive_alu(4'b1111, 32'd0, 32'h8000_0000, 32'd4 << 6, 1'b0, 1'b1, 5'd6);
        step();
        check("sra_ealu", ealu, 32'hF800_0000);

        drive_alu(4'b0111, 32'd0, 32'h8000_0000, 32'd4 << 6, 1'b0, 1'b1, 5'd6);
        step();
        check("srl_ealu", ealu, 32'h0800_0000);

        drive_alu(4'b0011, 32'd0, 32'd1, 32'd4 << 6, 1'b0, 1'b1, 5'd6);
        step();
        check("sll_ealu", ealu, 32'h0000_0010);

        drive_alu(4'b0001, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 1'b0, 1'b0, 5'd7);
        step();
        check("and_ealu", ealu, 32'h0000_F000);

        drive_alu(4'b0101, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 1'b0, 1'b0, 5'd7);
        step();
        check("or_ealu", ealu, 32'h0000_FFF0);

        drive_alu(4'b0010, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 1'b0, 1'b0, 5'd7);
        step();
        check("xor_ealu", ealu, 32'h0000_0FF0);

        // jal: link address and r31
        drive_nop();
        dpc4 = 32'h0040_0008; jal = 1'b1; wreg = 1'b1; rn = 5'd5; a = 32'd9; b = 32'd9;
        step();
        check("jal_ealu", ealu, 32'h0040_000C);
        check("jal_ern", {27'd0, ern}, 32'd31);
        drive_nop();
        step();
        check("jal_mrn", {27'd0, mrn}, 32'd31);
        check("jal_malu", malu, 32'h0040_000C);
        check("jal_mwreg", {31'd0, mwreg}, 32'd1);

        // stall bubble, then the same instruction re-presented
        drive_nop();
        wreg = 1'b1; wmem = 1'b1; m2reg = 1'b1; rn = 5'd7; nostall = 1'b0;
        step();
        check("stall_ewreg", {31'd0, ewreg}, 32'd0);
        check("stall_ewmem", {31'd0, ewmem}, 32'd0);
        check("stall_em2reg", {31'd0, em2reg}, 32'd0);
        nostall = 1'b1;
        step();
        check("stall_mwreg", {31'd0, mwreg}, 32'd0);
        check("stall_mwmem", {31'd0, mwmem}, 32'd0);
        check("replay_ewreg", {31'd0, ewreg}, 32'd1);
        check("replay_ewmem", {31'd0, ewmem}, 32'd1);
        check("replay_ern", {27'd0, ern}, 32'd7);

        // store: address = a + imm, data = b
        drive_nop();
        wmem = 1'b1; aluimm = 1'b1; a = 32'h100; imm = 32'd8; b = 32'hDEAD_BEEF;
        step();
        drive_nop();
        step();
        check("st_malu", malu, 32'h0000_0108);
        check("st_mb", mb, 32'hDEAD_BEEF);
        check("st_mwmem", {31'd0, mwmem}, 32'd1);
        check("st_mwreg", {31'd0, mwreg}, 32'd0);

        // asynchronous reset with two instructions in flight
        drive_alu(4'b0000, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0, 5'd9);
        step();
        drive_alu(4'b0000, 32'd3, 32'd4, 32'd0, 1'b0, 1'b0, 5'd10);
        wmem = 1'b1;
        step();
        check("pre_ewreg", {31'd0, ewreg}, 32'd1);
        check("pre_mwreg", {31'd0, mwreg}, 32'd1);
        check("pre_ealu", ealu, 32'd7);
        #2;
        clrn = 1'b0;
        #1;
        check("arst_ewreg", {31'd0, ewreg}, 32'd0);
        check("arst_ewmem", {31'd0, ewmem}, 32'd0);
        check("arst_ern", {27'd0, ern}, 32'd0);
        check("arst_ealu", ealu, 32'd0);
        check("arst_mwreg", {31'd0, mwreg}, 32'd0);
        check("arst_mrn", {27'd0, mrn}, 32'd0);
        check("arst_malu", malu, 32'd0);
        step();
        clrn = 1'b1;
        drive_nop();
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
